whiz_graphics: RTL and testbench

- Game Boy–style graphics peripheral on the system data bus.
- Holds sprite attribute memory (OAM) and the LCD control/status register file.
- Generates scanline/dot timing, the LCD mode and VBlank/STAT interrupt requests for the interrupt controller.
- The CPU reaches it through the shared DataBus; interrupt lines go out through Control.

---
 rtl/whiz_graphics.sv | 171 +++++++++++++++++
 tb/tb_whiz_graphics.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/whiz_graphics.sv
// Game Boy style LCD peripheral: OAM, LCD register file, dot/line timing and VBlank/STAT IRQs.
// Define WHIZ_OAM_LOCK_EN to block CPU access to OAM during modes 2 and 3 while the LCD is on.
module whiz_graphics #(
  parameter int                   DEBUG_OUT = 0,
  parameter int                   ADDR_SIZE = 16,
  parameter int                   DATA_SIZE = 8,
  parameter logic [ADDR_SIZE-1:0] OAM_LOC   = 16'hFE00,
  parameter int                   OAM_SIZE  = 160
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] db_addr,
  input  logic [DATA_SIZE-1:0] db_wdata,
  input  logic                 db_we,
  input  logic                 db_re,
  output logic [DATA_SIZE-1:0] db_rdata,
  output logic                 db_hit,
  output logic                 irq_vblank,
  output logic                 irq_stat
);
  localparam int OW = $clog2(OAM_SIZE);
  localparam logic [ADDR_SIZE-1:0] A_LCDC = ADDR_SIZE'(16'hFF40);
  localparam logic [ADDR_SIZE-1:0] A_STAT = ADDR_SIZE'(16'hFF41);
  localparam logic [ADDR_SIZE-1:0] A_SCY  = ADDR_SIZE'(16'hFF42);
  localparam logic [ADDR_SIZE-1:0] A_SCX  = ADDR_SIZE'(16'hFF43);
  localparam logic [ADDR_SIZE-1:0] A_LY   = ADDR_SIZE'(16'hFF44);
  localparam logic [ADDR_SIZE-1:0] A_LYC  = ADDR_SIZE'(16'hFF45);
  localparam logic [ADDR_SIZE-1:0] A_BGP  = ADDR_SIZE'(16'hFF47);
  localparam logic [ADDR_SIZE-1:0] A_OBP0 = ADDR_SIZE'(16'hFF48);
  localparam logic [ADDR_SIZE-1:0] A_OBP1 = ADDR_SIZE'(16'hFF49);
  localparam logic [ADDR_SIZE-1:0] A_WY   = ADDR_SIZE'(16'hFF4A);
  localparam logic [ADDR_SIZE-1:0] A_WX   = ADDR_SIZE'(16'hFF4B);

  typedef enum logic [1:0] {M_HBLANK = 2'd0, M_VBLANK = 2'd1, M_OAM = 2'd2, M_XFER = 2'd3} mode_t;

  logic [DATA_SIZE-1:0] oam [OAM_SIZE];
  logic [DATA_SIZE-1:0] lcdc, scy, scx, lyc, bgp, obp0, obp1, wy, wx;
  logic [3:0]           stat_en;
  logic [8:0]           dot;
  logic [7:0]           ly;
  mode_t                mode;
  logic                 lcd_on, lcd_on_next, coin, stat_line, stat_line_q, oam_lock;
  logic [ADDR_SIZE-1:0] oam_off;
  logic [OW-1:0]        oam_idx;
  logic                 oam_sel, rd_hit;
  logic [DATA_SIZE-1:0] rd_val;

  assign lcd_on = lcdc[7];
  // Coincidence only counts while the LCD runs, so the idle STAT reads back 0x80.
  assign coin   = lcd_on && (DATA_SIZE'(ly) == lyc);

  always_comb begin
    mode = M_HBLANK;
    if (lcd_on) begin
      if (ly >= 8'd144)      mode = M_VBLANK;
      else if (dot < 9'd80)  mode = M_OAM;
      else if (dot < 9'd252) mode = M_XFER;
      else                   mode = M_HBLANK;
    end
  end

  assign stat_line = (stat_en[3] & coin) | (stat_en[2] & (mode == M_OAM)) |
                     (stat_en[1] & (mode == M_VBLANK)) | (stat_en[0] & (mode == M_HBLANK));
  assign irq_stat  = stat_line & ~stat_line_q;

  // Offset compare also rejects addresses below OAM_LOC via wraparound.
  assign oam_off = db_addr - OAM_LOC;
  assign oam_sel = oam_off < ADDR_SIZE'(OAM_SIZE);
  assign oam_idx = oam_off[OW-1:0];

`ifdef WHIZ_OAM_LOCK_EN
  assign oam_lock = lcd_on && (mode == M_OAM || mode == M_XFER);
`else
  assign oam_lock = 1'b0;
`endif

  always_comb begin
    rd_hit = 1'b1;
    rd_val = '0;
    if (oam_sel) begin
      rd_val = oam_lock ? '1 : oam[oam_idx];
    end else begin
      case (db_addr)
        A_LCDC:  rd_val = lcdc;
        A_STAT:  rd_val = DATA_SIZE'({1'b1, stat_en, coin, mode});
        A_SCY:   rd_val = scy;
        A_SCX:   rd_val = scx;
        A_LY:    rd_val = DATA_SIZE'(ly);
        A_LYC:   rd_val = lyc;
        A_BGP:   rd_val = bgp;
        A_OBP0:  rd_val = obp0;
        A_OBP1:  rd_val = obp1;
        A_WY:    rd_val = wy;
        A_WX:    rd_val = wx;
        default: rd_hit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < OAM_SIZE; i++) oam[i] <= '0;
      lcdc <= '0; stat_en <= '0; scy <= '0; scx <= '0; lyc <= '0;
      bgp  <= DATA_SIZE'(8'hFC); obp0 <= '0; obp1 <= '0; wy <= '0; wx <= '0;
    end else if (db_we) begin
      if (oam_sel) begin
        if (!oam_lock) oam[oam_idx] <= db_wdata;
      end else begin
        case (db_addr)
          A_LCDC:  lcdc    <= db_wdata;
          A_STAT:  stat_en <= db_wdata[6:3];
          A_SCY:   scy     <= db_wdata;
          A_SCX:   scx     <= db_wdata;
          A_LYC:   lyc     <= db_wdata;
          A_BGP:   bgp     <= db_wdata;
          A_OBP0:  obp0    <= db_wdata;
          A_OBP1:  obp1    <= db_wdata;
          A_WY:    wy      <= db_wdata;
          A_WX:    wx      <= db_wdata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_rdata <= '0;
      db_hit   <= 1'b0;
    end else if (db_re) begin
      db_rdata <= rd_hit ? rd_val : '0;
      db_hit   <= rd_hit;
    end else begin
      db_rdata <= '0;
      db_hit   <= 1'b0;
    end
  end

  // Counters clear on the same edge LCDC[7] is written low, and stay at 0,0 on the enabling edge.
  assign lcd_on_next = (db_we && !oam_sel && db_addr == A_LCDC) ? db_wdata[7] : lcd_on;

  always_ff @(posedge clk) begin
    if (reset) begin
      dot         <= '0;
      ly          <= '0;
      irq_vblank  <= 1'b0;
      stat_line_q <= 1'b0;
    end else begin
      stat_line_q <= stat_line;
      irq_vblank  <= 1'b0;
      if (!lcd_on || !lcd_on_next) begin
        dot <= '0;
        ly  <= '0;
      end else if (dot == 9'd455) begin
        dot        <= '0;
        ly         <= (ly == 8'd153) ? 8'd0 : ly + 8'd1;
        irq_vblank <= (ly == 8'd143);
      end else begin
        dot <= dot + 9'd1;
      end
    end
  end

  generate
    if (DEBUG_OUT != 0) begin : g_debug
`ifndef SYNTHESIS
      always @(posedge clk) if (db_we) $display("whiz_graphics wr %h <= %h", db_addr, db_wdata);
`endif
    end
  endgenerate
endmodule

// File: tb/tb_whiz_graphics.sv
// Directed bench for whiz_graphics: read responses are checked against a queue of expected values.
module tb_whiz_graphics;
  logic        clk = 1'b0, reset = 1'b1;
  logic [15:0] db_addr = '0;
  logic [7:0]  db_wdata = '0, db_rdata;
  logic        db_we = 1'b0, db_re = 1'b0, db_hit, irq_vblank, irq_stat;
  int tests = 0, fails = 0;

  typedef struct { logic [7:0] data; logic hit; string tag; } exp_t;
  exp_t sb[$];
  logic [7:0] oam_m [160];

  always #5 clk = ~clk;

  whiz_graphics dut (
    .clk(clk), .reset(reset), .db_addr(db_addr), .db_wdata(db_wdata), .db_we(db_we),
    .db_re(db_re), .db_rdata(db_rdata), .db_hit(db_hit), .irq_vblank(irq_vblank), .irq_stat(irq_stat)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue_rd(input logic [15:0] a, input logic [7:0] d, input logic h, input string tag);
    db_addr = a;
    db_re   = 1'b1;
    sb.push_back('{data: d, hit: h, tag: tag});
  endtask

  task automatic check_rsp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "/hit"}, db_hit, e.hit);
      chk({e.tag, "/data"}, db_rdata, e.data);
    end
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] d, input logic h, input string tag);
    @(negedge clk);
    issue_rd(a, d, h, tag);
    @(posedge clk); #1;
    db_re = 1'b0;
    check_rsp();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    db_addr  = a;
    db_wdata = d;
    db_we    = 1'b1;
    @(posedge clk); #1;
    db_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 160; i++) oam_m[i] = 8'h00;
  endtask

  initial begin
    int cnt, first;
    for (int i = 0; i < 160; i++) oam_m[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rdata", db_rdata, 0);
    chk("rst_hit", db_hit, 0);
    chk("rst_vblank", irq_vblank, 0);
    chk("rst_stat", irq_stat, 0);
    reset = 1'b0;
    rd(16'hFF40, 8'h00, 1'b1, "rst_lcdc");
    rd(16'hFF47, 8'hFC, 1'b1, "rst_bgp");
    rd(16'hFE00, 8'h00, 1'b1, "rst_oam0");
    rd(16'hFF41, 8'h80, 1'b1, "rst_stat_reg");

    // LY is read-only; STAT keeps only bits 6:3
    wr(16'hFF44, 8'hAB);
    rd(16'hFF44, 8'h00, 1'b1, "ly_ro");
    wr(16'hFF41, 8'hFF);
    rd(16'hFF41, 8'hF8, 1'b1, "stat_mask");
    wr(16'hFF41, 8'h00);
    wr(16'hFF4B, 8'h5A);
    rd(16'hFF4B, 8'h5A, 1'b1, "wx_rw");

    // Full OAM write / immediate read-back
    for (int i = 0; i < 160; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      oam_m[i] = d;
      wr(16'hFE00 + 16'(i), d);
      rd(16'hFE00 + 16'(i), d, 1'b1, $sformatf("oam_%0h", 16'hFE00 + 16'(i)));
    end

    // Unmapped addresses and out-of-range OAM write
    wr(16'hFEA0, 8'h55);
    rd(16'hFEA0, 8'h00, 1'b0, "unmap_fea0");
    rd(16'hFF4C, 8'h00, 1'b0, "unmap_ff4c");
    rd(16'hFF46, 8'h00, 1'b0, "unmap_ff46");
    rd(16'hFE9F, oam_m[159], 1'b1, "oam_last_kept");
    rd(16'hFE00, oam_m[0], 1'b1, "oam_first_kept");

    // Simultaneous write and read: read sees the old value
    @(negedge clk);
    db_wdata = 8'h3C;
    db_we    = 1'b1;
    issue_rd(16'hFF42, 8'h00, 1'b1, "wr_rd_same");
    @(posedge clk); #1;
    db_we = 1'b0;
    db_re = 1'b0;
    check_rsp();
    rd(16'hFF42, 8'h3C, 1'b1, "wr_rd_after");

    // Run 144 lines: one VBlank pulse exactly on entry to line 144
    do_reset();
    wr(16'hFF40, 8'h80);
    cnt = 0; first = -1;
    for (int k = 0; k < 65700; k++) begin
      @(negedge clk);
      if (irq_vblank) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    chk("vblank_count", cnt, 1);
    chk("vblank_time", first, 65664);
    rd(16'hFF44, 8'd144, 1'b1, "ly_144");
    rd(16'hFF41, 8'h81, 1'b1, "stat_mode1");

    // LYC coincidence interrupt at LY=2, dot 0
    do_reset();
    wr(16'hFF45, 8'h02);
    wr(16'hFF41, 8'h40);
    wr(16'hFF40, 8'h80);
    cnt = 0; first = -1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (irq_stat) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    chk("stat_irq_count", cnt, 1);
    chk("stat_irq_time", first, 912);
    rd(16'hFF41, 8'hC7, 1'b1, "stat_coin");
    rd(16'hFF44, 8'h02, 1'b1, "ly_2");

    // Reset with a read in flight drops the response and stops the LCD
    @(negedge clk);
    db_addr = 16'hFF47;
    db_re   = 1'b1;
    reset   = 1'b1;
    @(posedge clk); #1;
    db_re = 1'b0;
    reset = 1'b0;
    chk("rst_drop_hit", db_hit, 0);
    chk("rst_drop_data", db_rdata, 0);
    rd(16'hFF44, 8'h00, 1'b1, "rst_ly");
    rd(16'hFF40, 8'h00, 1'b1, "rst_lcdc_mid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
